vga_timing_gen: RTL and testbench

//  Generates 640x480@60Hz VGA raster timing: pixel column/row counters, active-video enable, and

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz raster timing generator.
// Produces column/row counters, active-video enable, active-low hsync/vsync,
// a frame-start marker and a frame-counted ~1 Hz square wave. All outputs are
// registered and computed from the next-state counters, so they always
// describe the (col,row) presented on the same cycle.
module vga_timing_gen #(
    parameter int H_ACTIVE           = 640,
    parameter int H_FP               = 16,
    parameter int H_SYNC             = 96,
    parameter int H_BP               = 48,
    parameter int V_ACTIVE           = 480,
    parameter int V_FP               = 10,
    parameter int V_SYNC             = 2,
    parameter int V_BP               = 33,
    parameter int HALF_PERIOD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       clk_1hz
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries sized to the counter width so every compare is 10 bits.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Frame counter only needs to reach HALF_PERIOD_FRAMES-1; keep at least one bit.
    localparam int              FC_W    = (HALF_PERIOD_FRAMES > 1) ? $clog2(HALF_PERIOD_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(HALF_PERIOD_FRAMES - 1);

    logic [9:0]      col_q, col_d;
    logic [9:0]      row_q, row_d;
    logic            enable_q, enable_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            frame_start_q, frame_start_d;
    logic            clk_1hz_q, clk_1hz_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

    // Next-state: advance the raster on pix_en and derive the aligned outputs from it.
    always_comb begin
        // NOTE: every _d starts as its _q (hold), so no path through this block can infer a latch.
        col_d         = col_q;
        row_d         = row_q;
        enable_d      = enable_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = frame_start_q;
        clk_1hz_d     = clk_1hz_q;
        frame_cnt_d   = frame_cnt_q;

        if (pix_en) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end

            enable_d      = (col_d < H_ACT_END) && (row_d < V_ACT_END);
            hsync_d       = !((col_d >= HS_START) && (col_d < HS_END));
            vsync_d       = !((row_d >= VS_START) && (row_d < VS_END));
            frame_start_d = (col_d == '0) && (row_d == '0);

            if (frame_start_d) begin
                if (frame_cnt_q == FC_LAST) begin
                    frame_cnt_d = '0;
                    clk_1hz_d   = !clk_1hz_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                end
            end
        end
    end

    // State registers with synchronous reset; reset parks the raster in back porch.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update together from pre-edge values.
        if (reset) begin
            col_q         <= H_LAST;
            row_q         <= V_LAST;
            enable_q      <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            clk_1hz_q     <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            enable_q      <= enable_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            clk_1hz_q     <= clk_1hz_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign enable      = enable_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign clk_1hz     = clk_1hz_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Two instances share stimulus: one at full 640x480 geometry (reset values,
// line timing) and one with a tiny geometry and HALF_PERIOD_FRAMES=2 so that
// whole frames, vsync and clk_1hz toggles fit in a short run. The reference
// model derives every output from the count of pix_en edges since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       en;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       c1;
    } vis_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    // Full-size DUT outputs.
    logic [9:0] f_col, f_row;
    logic       f_en, f_hs, f_vs, f_fs, f_c1;
    // Small-geometry DUT outputs.
    logic [9:0] s_col, s_row;
    logic       s_en, s_hs, s_vs, s_fs, s_c1;

    vga_timing_gen u_full (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .col(f_col), .row(f_row), .enable(f_en), .hsync(f_hs), .vsync(f_vs),
        .frame_start(f_fs), .clk_1hz(f_c1)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HALF_PERIOD_FRAMES(2)
    ) u_small (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .col(s_col), .row(s_row), .enable(s_en), .hsync(s_hs), .vsync(s_vs),
        .frame_start(s_fs), .clk_1hz(s_c1)
    );

    vis_t full_q[$];
    vis_t small_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_edges = 0;   // pix_en edges since last reset edge

    // Reference: position is the (n-1)th pixel of the repeating raster; frames entered = f.
    function automatic vis_t ref_vis(input int n, input int ha, input int hfp, input int hs,
                                     input int hbp, input int va, input int vfp, input int vs,
                                     input int vbp, input int hpf);
        vis_t v;
        int   ht, vt, idx, c, r, f;
        ht = ha + hfp + hs + hbp;
        vt = va + vfp + vs + vbp;
        if (n == 0) begin
            c = ht - 1;
            r = vt - 1;
            f = 0;
        end else begin
            idx = (n - 1) % (ht * vt);
            c   = idx % ht;
            r   = idx / ht;
            f   = (n - 1) / (ht * vt) + 1;
        end
        v.col = 10'(c);
        v.row = 10'(r);
        v.en  = (c < ha) && (r < va);
        v.hs  = !((c >= ha + hfp) && (c < ha + hfp + hs));
        v.vs  = !((r >= va + vfp) && (r < va + vfp + vs));
        v.fs  = (n != 0) && (c == 0) && (r == 0);
        v.c1  = ((f / hpf) % 2) == 1;
        return v;
    endfunction

    task automatic check(input string name, input vis_t act, input vis_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got col=%0d row=%0d en=%b hs=%b vs=%b fs=%b c1=%b, want col=%0d row=%0d en=%b hs=%b vs=%b fs=%b c1=%b",
                     name, act.col, act.row, act.en, act.hs, act.vs, act.fs, act.c1,
                     exp.col, exp.row, exp.en, exp.hs, exp.vs, exp.fs, exp.c1);
        end
    endtask

    // Drive one clock's inputs before the rising edge and queue what both DUTs must show after it.
    task automatic step(input logic r, input logic p);
        @(negedge clk);
        reset  = r;
        pix_en = p;
        if (r) n_edges = 0;
        else if (p) n_edges++;
        full_q.push_back(ref_vis(n_edges, 640, 16, 96, 48, 480, 10, 2, 33, 30));
        small_q.push_back(ref_vis(n_edges, 16, 4, 6, 6, 12, 2, 2, 3, 2));
    endtask

    // Monitor: one observation per rising edge, sampled 1 time unit after it.
    initial begin
        vis_t a;
        wait (full_q.size() > 0);
        forever begin
            @(posedge clk);
            #1;
            if (full_q.size() == 0 || small_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL queue_underflow: got empty scoreboard, want a pending expectation");
            end else begin
                a = '{f_col, f_row, f_en, f_hs, f_vs, f_fs, f_c1};
                check("full", a, full_q.pop_front());
                a = '{s_col, s_row, s_en, s_hs, s_vs, s_fs, s_c1};
                check("small", a, small_q.pop_front());
            end
        end
    end

    // Stimulus.
    initial begin
        int guard;
        // Reset held three cycles with pix_en high.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        // Free run: five full-size lines, several small frames and clk_1hz toggles.
        for (int i = 0; i < 4000; i++) step(1'b0, 1'b1);
        // 50 MHz-style strobe: advance every other clock.
        for (int i = 0; i < 1000; i++) step(1'b0, 1'(i % 2 == 0));
        // Irregular strobe.
        for (int i = 0; i < 3000; i++) step(1'b0, 1'(($urandom % 4) != 0));
        // Run to full-size col 300, then pulse reset with pix_en high.
        guard = 0;
        while (((n_edges - 1) % 800) != 300 && guard < 2000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        if (guard >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL reach_col300: got no col 300 within %0d cycles, want col 300", guard);
        end
        step(1'b1, 1'b1);
        // Resume after reset, with a mildly irregular strobe at the end.
        for (int i = 0; i < 1500; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 500; i++) step(1'b0, 1'($urandom % 2));
        @(posedge clk);
        #2;
        if (full_q.size() != 0 || small_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL queue_drain: got %0d/%0d left, want 0/0", full_q.size(), small_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
